halo_phase_sequencer: RTL and testbench

Sequencer for the halo-resolve datapath. Holds two configuration banks: phase 0 is the horizontal (left) resolve and phase 1 is the vertical (top) resolve. On `start` it runs each enabled phase in order. For each phase it drives `isLeft` and the phase's configuration buses, re-arms the address control path, waits for the control path to go idle, then drains the RAM/hand-off pipeline. It sits between the host configuration port and the control path / PE-array control inputs.

---
 rtl/halo_seq_pkg.sv | 55 +++++
 rtl/halo_cfg_bank.sv | 66 ++++++
 rtl/halo_phase_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_halo_phase_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halo_seq_pkg.sv
// Shared constants, FSM state encoding and per-phase configuration payload
// for the halo-resolve phase sequencer.
package halo_seq_pkg;

   localparam int unsigned LINE_W    = 9;
   localparam int unsigned BANK_LOG2 = 3;
   localparam int unsigned AW        = LINE_W - BANK_LOG2;
   localparam int unsigned NLANE     = 2 ** BANK_LOG2;
   localparam int unsigned NINC      = 3;
   localparam int unsigned FIELD_W   = 4;

   localparam logic [FIELD_W-1:0] F_EOF       = 4'd0;
   localparam logic [FIELD_W-1:0] F_NUMITERS  = 4'd1;
   localparam logic [FIELD_W-1:0] F_RAMROT    = 4'd2;
   localparam logic [FIELD_W-1:0] F_EN        = 4'd3;
   localparam logic [FIELD_W-1:0] F_INIT_SEND = 4'd4;
   localparam logic [FIELD_W-1:0] F_LAST_SEND = 4'd5;
   localparam logic [FIELD_W-1:0] F_INIT_RECV = 4'd6;
   localparam logic [FIELD_W-1:0] F_LAST_RECV = 4'd7;
   localparam logic [FIELD_W-1:0] F_INCR_TRG0 = 4'd8;
   localparam logic [FIELD_W-1:0] F_INCR_TRG1 = 4'd9;
   localparam logic [FIELD_W-1:0] F_INCR_TRG2 = 4'd10;
   localparam logic [FIELD_W-1:0] F_INCR_VAL0 = 4'd11;
   localparam logic [FIELD_W-1:0] F_INCR_VAL1 = 4'd12;
   localparam logic [FIELD_W-1:0] F_INCR_VAL2 = 4'd13;
   localparam logic [FIELD_W-1:0] F_RSVD_LO   = 4'd14;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ARM   = 3'd2,
      S_RUN   = 3'd3,
      S_DRAIN = 3'd4,
      S_FIN   = 3'd5
   } state_e;

   // One resolve phase's worth of control-path / PE-array configuration.
   typedef struct packed {
      logic [AW-1:0]                   eof;
      logic [AW-1:0]                   numiters;
      logic [BANK_LOG2-1:0]            ramrot;
      logic [NLANE-1:0]                en;
      logic [NLANE-1:0][AW-1:0]        init_halo_send;
      logic [NLANE-1:0][AW-1:0]        last_halo_send;
      logic [NLANE-1:0][AW-1:0]        init_halo_recv;
      logic [NLANE-1:0][AW-1:0]        last_halo_recv;
      logic [NINC-1:0][AW-1:0]         incr_trg;
      logic [NINC-1:0][AW-1:0]         incr_val;
   } phase_cfg_t;

   function automatic logic field_reserved(input logic [FIELD_W-1:0] f);
      return (f >= F_RSVD_LO);
   endfunction

endpackage

// File: rtl/halo_cfg_bank.sv
// Two-entry configuration bank (horizontal / vertical) with field/lane write
// decode, rejected-write flag and combinational read-out of one entry.
module halo_cfg_bank
   import halo_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_we,
   input  logic                 i_open,
   input  logic                 i_phase,
   input  logic [FIELD_W-1:0]   i_field,
   input  logic [BANK_LOG2-1:0] i_lane,
   input  logic [AW-1:0]        i_data,
   input  logic                 i_rd_phase,
   output phase_cfg_t           o_rd_c,
   output logic                 o_rej
);

   phase_cfg_t r_bank [2];
   phase_cfg_t w_upd;
   logic       r_rej;
   logic       w_accept;
   logic       w_reject;

   assign w_accept = i_we && i_open && !field_reserved(i_field);
   assign w_reject = i_we && !w_accept;

   // Merge the incoming write into a copy of the addressed entry.
   always_comb begin
      w_upd = r_bank[i_phase];
      case (i_field)
         F_EOF:       w_upd.eof                    = i_data;
         F_NUMITERS:  w_upd.numiters               = i_data;
         F_RAMROT:    w_upd.ramrot                 = i_data[BANK_LOG2-1:0];
         F_EN:        w_upd.en[i_lane]             = i_data[0];
         F_INIT_SEND: w_upd.init_halo_send[i_lane] = i_data;
         F_LAST_SEND: w_upd.last_halo_send[i_lane] = i_data;
         F_INIT_RECV: w_upd.init_halo_recv[i_lane] = i_data;
         F_LAST_RECV: w_upd.last_halo_recv[i_lane] = i_data;
         F_INCR_TRG0: w_upd.incr_trg[0]            = i_data;
         F_INCR_TRG1: w_upd.incr_trg[1]            = i_data;
         F_INCR_TRG2: w_upd.incr_trg[2]            = i_data;
         F_INCR_VAL0: w_upd.incr_val[0]            = i_data;
         F_INCR_VAL1: w_upd.incr_val[1]            = i_data;
         F_INCR_VAL2: w_upd.incr_val[2]            = i_data;
         default:     ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bank[0] <= '0;
         r_bank[1] <= '0;
         r_rej     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_bank[i_phase] <= w_upd;
         end
         r_rej <= w_reject;
      end
   end

   assign o_rd_c = r_bank[i_rd_phase];
   assign o_rej  = r_rej;

endmodule

// File: rtl/halo_phase_sequencer.sv
// Runs the enabled halo-resolve phases (horizontal then vertical): load, arm,
// run, drain. Optional RUN watchdog is built when HALO_SEQ_WDOG_EN is defined.
module halo_phase_sequencer
   import halo_seq_pkg::*;
#(
   parameter int unsigned LINWDTH  = LINE_W,
   parameter int unsigned ADDRLEN  = BANK_LOG2,
   parameter int unsigned DRAINCYC = 3,
   parameter int unsigned WDOGW    = 10
)(
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     start,
   input  logic                                     abort,
   input  logic                                     cfgWe,
   input  logic                                     cfgPhase,
   input  logic [3:0]                               cfgField,
   input  logic [ADDRLEN-1:0]                       cfgLane,
   input  logic [LINWDTH-ADDRLEN-1:0]               cfgData,
   input  logic                                     cpBusy,
   output logic                                     cpReset_n,
   output logic                                     isLeft,
   output logic [LINWDTH-ADDRLEN-1:0]               EOF,
   output logic [LINWDTH-ADDRLEN-1:0]               NUMITERS,
   output logic [ADDRLEN-1:0]                       RAMROT,
   output logic [2**ADDRLEN-1:0]                    en,
   output logic [(2**ADDRLEN)*(LINWDTH-ADDRLEN)-1:0] initHaloSend,
   output logic [(2**ADDRLEN)*(LINWDTH-ADDRLEN)-1:0] lastHaloSend,
   output logic [(2**ADDRLEN)*(LINWDTH-ADDRLEN)-1:0] initHaloRecv,
   output logic [(2**ADDRLEN)*(LINWDTH-ADDRLEN)-1:0] lastHaloRecv,
   output logic [3*(LINWDTH-ADDRLEN)-1:0]           incrTrg,
   output logic [3*(LINWDTH-ADDRLEN)-1:0]           incrVal,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     cfgRej,
   output logic                                     err
);

   localparam int unsigned DCW = (DRAINCYC > 1) ? $clog2(DRAINCYC) : 1;

   state_e           r_state;
   state_e           w_state_nxt;
   logic             r_phase;
   logic             w_phase_nxt;
   logic [DCW-1:0]   r_drain;
   logic             r_run_first;
   logic             w_wdog_trip;
   phase_cfg_t       w_bank_rd;
   phase_cfg_t       r_cfg;
   logic             r_is_left;
   logic             r_cp_rst_n;
   logic             w_cp_rst_n_nxt;
   logic             r_busy;
   logic             r_done;
   logic             w_bank_rej;

   halo_cfg_bank u_bank (
      .clk        (clk),
      .reset      (reset),
      .i_we       (cfgWe),
      .i_open     (r_state == S_IDLE),
      .i_phase    (cfgPhase),
      .i_field    (cfgField),
      .i_lane     (cfgLane),
      .i_data     (cfgData),
      .i_rd_phase (r_phase),
      .o_rd_c     (w_bank_rd),
      .o_rej      (w_bank_rej)
   );

   // Next state, next phase and next re-arm level; abort overrides everything.
   always_comb begin
      w_state_nxt    = r_state;
      w_phase_nxt    = r_phase;
      w_cp_rst_n_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_phase_nxt = 1'b0;
            if (start) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_bank_rd.en == '0) begin
               if (r_phase) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_phase_nxt = 1'b1;
               end
            end else begin
               w_state_nxt = S_ARM;
            end
         end
         S_ARM: begin
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_wdog_trip) begin
               w_state_nxt = S_IDLE;
            end else if (!r_run_first && !cpBusy) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_drain == DCW'(DRAINCYC - 1)) begin
               if (r_phase) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_phase_nxt = 1'b1;
                  w_state_nxt = S_LOAD;
               end
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (abort) begin
         w_state_nxt = S_IDLE;
         w_phase_nxt = 1'b0;
      end

      // LOAD keeps the current level so a second-phase re-arm is a single ARM cycle.
      case (w_state_nxt)
         S_RUN, S_DRAIN: w_cp_rst_n_nxt = 1'b1;
         S_LOAD:         w_cp_rst_n_nxt = r_cp_rst_n;
         default:        w_cp_rst_n_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_phase     <= 1'b0;
         r_drain     <= '0;
         r_run_first <= 1'b0;
         r_cfg       <= '0;
         r_is_left   <= 1'b1;
         r_cp_rst_n  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_phase     <= w_phase_nxt;
         r_run_first <= (r_state == S_ARM);
         r_drain     <= (r_state == S_DRAIN) ? r_drain + DCW'(1) : '0;
         if (r_state == S_LOAD) begin
            r_cfg     <= w_bank_rd;
            r_is_left <= !r_phase;
         end
         r_cp_rst_n  <= w_cp_rst_n_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_FIN);
      end
   end

`ifdef HALO_SEQ_WDOG_EN
   logic [WDOGW-1:0] r_wdog;
   logic [WDOGW-1:0] w_wdog_inc;
   logic             r_err;
   logic             w_start_ok;

   assign w_wdog_inc  = r_wdog + WDOGW'(1);
   assign w_wdog_trip = (r_state == S_RUN) && (w_wdog_inc == '1);
   assign w_start_ok  = (r_state == S_IDLE) && start && !abort;

   // Counts RUN cycles; trips in the RUN cycle that brings the count to all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         r_wdog <= (r_state == S_RUN) ? w_wdog_inc : '0;
         if (w_wdog_trip) begin
            r_err <= 1'b1;
         end else if (w_start_ok) begin
            r_err <= 1'b0;
         end
      end
   end

   assign err = r_err;
`else
   logic w_unused_wdog;

   assign w_wdog_trip   = 1'b0;
   assign w_unused_wdog = |(WDOGW'(1'b0));
   assign err           = 1'b0;
`endif

   assign cpReset_n    = r_cp_rst_n;
   assign isLeft       = r_is_left;
   assign EOF          = r_cfg.eof;
   assign NUMITERS     = r_cfg.numiters;
   assign RAMROT       = r_cfg.ramrot;
   assign en           = r_cfg.en;
   assign initHaloSend = r_cfg.init_halo_send;
   assign lastHaloSend = r_cfg.last_halo_send;
   assign initHaloRecv = r_cfg.init_halo_recv;
   assign lastHaloRecv = r_cfg.last_halo_recv;
   assign incrTrg      = r_cfg.incr_trg;
   assign incrVal      = r_cfg.incr_val;
   assign busy         = r_busy;
   assign done         = r_done;
   assign cfgRej       = w_bank_rej;

endmodule

// File: tb/tb_halo_phase_sequencer.sv
// Directed bench for halo_phase_sequencer: reset values, one- and two-phase
// sequences, rejected writes, abort precedence, watchdog and mid-run reset.
module tb_halo_phase_sequencer;

   localparam int unsigned TAW = 6;
   localparam int unsigned TNL = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic             cfgWe;
   logic             cfgPhase;
   logic [3:0]       cfgField;
   logic [2:0]       cfgLane;
   logic [TAW-1:0]   cfgData;
   logic             cpBusy;
   logic             cpReset_n;
   logic             isLeft;
   logic [TAW-1:0]   EOF;
   logic [TAW-1:0]   NUMITERS;
   logic [2:0]       RAMROT;
   logic [TNL-1:0]   en;
   logic [TNL*TAW-1:0] initHaloSend;
   logic [TNL*TAW-1:0] lastHaloSend;
   logic [TNL*TAW-1:0] initHaloRecv;
   logic [TNL*TAW-1:0] lastHaloRecv;
   logic [3*TAW-1:0] incrTrg;
   logic [3*TAW-1:0] incrVal;
   logic             busy;
   logic             done;
   logic             cfgRej;
   logic             err;

   int n_vec = 0;
   int n_err = 0;

   // Snapshot of the outputs at the first RUN cycle of each armed phase.
   logic             log_left [2];
   logic [TAW-1:0]   log_eof  [2];
   logic [TAW-1:0]   log_ni   [2];
   logic [2:0]       log_rot  [2];
   logic [TNL-1:0]   log_en   [2];
   logic [TNL*TAW-1:0] log_ihs [2];
   logic [3*TAW-1:0] log_itrg [2];
   logic [3*TAW-1:0] log_ival [2];
   int               seq_done_at;
   int               seq_n_done;
   int               seq_n_arm;

   halo_phase_sequencer #(
      .LINWDTH  (9),
      .ADDRLEN  (3),
      .DRAINCYC (3),
      .WDOGW    (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .cfgWe        (cfgWe),
      .cfgPhase     (cfgPhase),
      .cfgField     (cfgField),
      .cfgLane      (cfgLane),
      .cfgData      (cfgData),
      .cpBusy       (cpBusy),
      .cpReset_n    (cpReset_n),
      .isLeft       (isLeft),
      .EOF          (EOF),
      .NUMITERS     (NUMITERS),
      .RAMROT       (RAMROT),
      .en           (en),
      .initHaloSend (initHaloSend),
      .lastHaloSend (lastHaloSend),
      .initHaloRecv (initHaloRecv),
      .lastHaloRecv (lastHaloRecv),
      .incrTrg      (incrTrg),
      .incrVal      (incrVal),
      .busy         (busy),
      .done         (done),
      .cfgRej       (cfgRej),
      .err          (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input logic ph, input logic [3:0] f, input logic [2:0] ln,
                       input logic [TAW-1:0] d);
      cfgWe    = 1'b1;
      cfgPhase = ph;
      cfgField = f;
      cfgLane  = ln;
      cfgData  = d;
      tick();
      cfgWe    = 1'b0;
   endtask

   // Pulse start and follow the sequence; cpBusy drops in RUN cycle r of each phase.
   task automatic run_seq(input int r);
      int   k;
      logic prev_rn;
      seq_done_at = -1;
      seq_n_done  = 0;
      seq_n_arm   = 0;
      k           = 0;
      start = 1'b1;
      tick();
      start   = 1'b0;
      prev_rn = cpReset_n;
      for (int c = 0; c < 80; c++) begin
         if (!busy) break;
         if (done) begin
            seq_n_done++;
            if (seq_done_at < 0) seq_done_at = c;
         end
         if (cpReset_n && !prev_rn) begin
            if (seq_n_arm < 2) begin
               log_left[seq_n_arm] = isLeft;
               log_eof[seq_n_arm]  = EOF;
               log_ni[seq_n_arm]   = NUMITERS;
               log_rot[seq_n_arm]  = RAMROT;
               log_en[seq_n_arm]   = en;
               log_ihs[seq_n_arm]  = initHaloSend;
               log_itrg[seq_n_arm] = incrTrg;
               log_ival[seq_n_arm] = incrVal;
            end
            seq_n_arm++;
            k = 1;
         end else if (k > 0) begin
            k++;
         end
         cpBusy  = (k > 0) && (k < r);
         prev_rn = cpReset_n;
         tick();
      end
      cpBusy = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_vec++; if (cpReset_n !== 1'b0) begin n_err++; $display("FAIL rst_cpReset_n: got %b want 0", cpReset_n); end
      n_vec++; if (isLeft !== 1'b1) begin n_err++; $display("FAIL rst_isLeft: got %b want 1", isLeft); end
      n_vec++; if ({busy, done, cfgRej, err} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {busy, done, cfgRej, err}); end
      n_vec++; if ({EOF, NUMITERS, RAMROT, en} !== '0) begin n_err++; $display("FAIL rst_cfg: got %h want 0", {EOF, NUMITERS, RAMROT, en}); end
      n_vec++; if ({initHaloSend, lastHaloRecv, incrTrg, incrVal} !== '0) begin n_err++; $display("FAIL rst_vec: got %h want 0", {initHaloSend, lastHaloRecv, incrTrg, incrVal}); end
   endtask

   task automatic test_single_phase();
      logic [TNL*TAW-1:0] exp_ihs;
      logic [3*TAW-1:0]   exp_trg;
      logic [3*TAW-1:0]   exp_val;
      exp_ihs = '0; exp_ihs[2*TAW +: TAW] = 6'd9;
      exp_trg = '0; exp_trg[2*TAW +: TAW] = 6'd17;
      exp_val = '0; exp_val[1*TAW +: TAW] = 6'd33;
      prog(1'b0, 4'd0, 3'd0, 6'd5);
      prog(1'b0, 4'd1, 3'd0, 6'd2);
      prog(1'b0, 4'd2, 3'd0, 6'd3);
      for (int l = 0; l < 8; l++) prog(1'b0, 4'd3, 3'(l), 6'd1);
      prog(1'b0, 4'd4, 3'd2, 6'd9);
      prog(1'b0, 4'd10, 3'd0, 6'd17);
      prog(1'b0, 4'd12, 3'd0, 6'd33);
      n_vec++; if (cfgRej !== 1'b0) begin n_err++; $display("FAIL t1_valid_write_rej: got %b want 0", cfgRej); end
      run_seq(6);
      n_vec++; if (seq_done_at !== 12) begin n_err++; $display("FAIL t1_done_at: got %0d want 12", seq_done_at); end
      n_vec++; if (seq_n_done !== 1) begin n_err++; $display("FAIL t1_n_done: got %0d want 1", seq_n_done); end
      n_vec++; if (seq_n_arm !== 1) begin n_err++; $display("FAIL t1_n_arm: got %0d want 1", seq_n_arm); end
      n_vec++; if (log_left[0] !== 1'b1) begin n_err++; $display("FAIL t1_isLeft: got %b want 1", log_left[0]); end
      n_vec++; if ({log_eof[0], log_ni[0], log_rot[0], log_en[0]} !== {6'd5, 6'd2, 3'd3, 8'hFF}) begin n_err++; $display("FAIL t1_scalars: got %h want %h", {log_eof[0], log_ni[0], log_rot[0], log_en[0]}, {6'd5, 6'd2, 3'd3, 8'hFF}); end
      n_vec++; if (log_ihs[0] !== exp_ihs) begin n_err++; $display("FAIL t1_initHaloSend: got %h want %h", log_ihs[0], exp_ihs); end
      n_vec++; if ({log_itrg[0], log_ival[0]} !== {exp_trg, exp_val}) begin n_err++; $display("FAIL t1_incr: got %h want %h", {log_itrg[0], log_ival[0]}, {exp_trg, exp_val}); end
      n_vec++; if ({isLeft, EOF, busy, cpReset_n} !== {1'b0, 6'd0, 1'b0, 1'b0}) begin n_err++; $display("FAIL t1_after: got %h want 0", {isLeft, EOF, busy, cpReset_n}); end
   endtask

   task automatic test_two_phase();
      prog(1'b1, 4'd0, 3'd0, 6'd25);
      prog(1'b1, 4'd2, 3'd0, 6'd7);
      for (int l = 0; l < 4; l++) prog(1'b1, 4'd3, 3'(l), 6'd1);
      run_seq(3);
      n_vec++; if (seq_done_at !== 16) begin n_err++; $display("FAIL t2_done_at: got %0d want 16", seq_done_at); end
      n_vec++; if (seq_n_arm !== 2) begin n_err++; $display("FAIL t2_n_arm: got %0d want 2", seq_n_arm); end
      n_vec++; if (seq_n_done !== 1) begin n_err++; $display("FAIL t2_n_done: got %0d want 1", seq_n_done); end
      n_vec++; if ({log_left[0], log_left[1]} !== 2'b10) begin n_err++; $display("FAIL t2_isLeft: got %b want 10", {log_left[0], log_left[1]}); end
      n_vec++; if ({log_eof[0], log_eof[1]} !== {6'd5, 6'd25}) begin n_err++; $display("FAIL t2_eof: got %0d,%0d want 5,25", log_eof[0], log_eof[1]); end
      n_vec++; if ({log_rot[1], log_en[1]} !== {3'd7, 8'h0F}) begin n_err++; $display("FAIL t2_vert_cfg: got %h want %h", {log_rot[1], log_en[1]}, {3'd7, 8'h0F}); end
      n_vec++; if ({RAMROT, isLeft} !== {3'd7, 1'b0}) begin n_err++; $display("FAIL t2_after: got %h want %h", {RAMROT, isLeft}, {3'd7, 1'b0}); end
   endtask

   task automatic test_cfg_reject();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      prog(1'b0, 4'd0, 3'd0, 6'd63);
      n_vec++; if (cfgRej !== 1'b1) begin n_err++; $display("FAIL t3_rej_run: got %b want 1", cfgRej); end
      tick();
      n_vec++; if (cfgRej !== 1'b0) begin n_err++; $display("FAIL t3_rej_pulse: got %b want 0", cfgRej); end
      for (int c = 0; c < 60 && busy; c++) tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t3_finish: got busy=%b want 0", busy); end
      prog(1'b1, 4'd14, 3'd0, 6'd40);
      n_vec++; if (cfgRej !== 1'b1) begin n_err++; $display("FAIL t3_rej_f14: got %b want 1", cfgRej); end
      prog(1'b1, 4'd15, 3'd0, 6'd41);
      n_vec++; if (cfgRej !== 1'b1) begin n_err++; $display("FAIL t3_rej_f15: got %b want 1", cfgRej); end
      prog(1'b1, 4'd1, 3'd0, 6'd4);
      n_vec++; if (cfgRej !== 1'b0) begin n_err++; $display("FAIL t3_accept: got %b want 0", cfgRej); end
      run_seq(2);
      n_vec++; if ({log_eof[0], log_eof[1]} !== {6'd5, 6'd25}) begin n_err++; $display("FAIL t3_bank_kept: got %0d,%0d want 5,25", log_eof[0], log_eof[1]); end
      n_vec++; if (NUMITERS !== 6'd4) begin n_err++; $display("FAIL t3_numiters: got %0d want 4", NUMITERS); end
   endtask

   task automatic test_abort_drain();
      int bad;
      cpBusy = 1'b0;
      start  = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      n_vec++; if ({busy, cpReset_n} !== 2'b11) begin n_err++; $display("FAIL t4_in_drain: got %b want 11", {busy, cpReset_n}); end
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      n_vec++; if ({busy, cpReset_n, done} !== 3'b000) begin n_err++; $display("FAIL t4_abort: got %b want 000", {busy, cpReset_n, done}); end
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         if (busy || done) bad++;
         tick();
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL t4_stay_idle: got %0d busy/done cycles want 0", bad); end
   endtask

   task automatic test_watchdog();
`ifdef HALO_SEQ_WDOG_EN
      int run_cnt;
      int nd;
      run_cnt = 0;
      nd      = 0;
      cpBusy  = 1'b1;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (!busy) break;
         if (cpReset_n) run_cnt++;
         if (done) nd++;
         tick();
      end
      n_vec++; if (run_cnt !== 15) begin n_err++; $display("FAIL t5_run_cycles: got %0d want 15", run_cnt); end
      n_vec++; if ({err, busy, cpReset_n} !== 3'b100) begin n_err++; $display("FAIL t5_trip: got %b want 100", {err, busy, cpReset_n}); end
      n_vec++; if (nd !== 0) begin n_err++; $display("FAIL t5_no_done: got %0d want 0", nd); end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++; if ({err, busy} !== 2'b01) begin n_err++; $display("FAIL t5_err_clear: got %b want 01", {err, busy}); end
`else
      cpBusy = 1'b1;
      start  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      repeat (99) tick();
      n_vec++; if ({busy, cpReset_n, err, done} !== 4'b1100) begin n_err++; $display("FAIL t5_still_run: got %b want 1100", {busy, cpReset_n, err, done}); end
`endif
      abort  = 1'b1;
      tick();
      abort  = 1'b0;
      cpBusy = 1'b0;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t5_abort: got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid_run();
      cpBusy = 1'b1;
      start  = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      cpBusy = 1'b0;
      n_vec++; if ({cpReset_n, isLeft, busy, done, cfgRej, err} !== 6'b010000) begin n_err++; $display("FAIL t6_flags: got %b want 010000", {cpReset_n, isLeft, busy, done, cfgRej, err}); end
      n_vec++; if ({EOF, NUMITERS, RAMROT, en, initHaloSend} !== '0) begin n_err++; $display("FAIL t6_cfg: got %h want 0", {EOF, NUMITERS, RAMROT, en, initHaloSend}); end
      run_seq(2);
      n_vec++; if (seq_done_at !== 2) begin n_err++; $display("FAIL t6_skip_done_at: got %0d want 2", seq_done_at); end
      n_vec++; if (seq_n_arm !== 0) begin n_err++; $display("FAIL t6_no_arm: got %0d want 0", seq_n_arm); end
      n_vec++; if ({isLeft, EOF, RAMROT} !== {1'b0, 6'd0, 3'd0}) begin n_err++; $display("FAIL t6_banks_zero: got %h want 0", {isLeft, EOF, RAMROT}); end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      cfgWe    = 1'b0;
      cfgPhase = 1'b0;
      cfgField = 4'd0;
      cfgLane  = 3'd0;
      cfgData  = '0;
      cpBusy   = 1'b0;
      test_reset();
      test_single_phase();
      test_two_phase();
      test_cfg_reject();
      test_abort_drain();
      test_watchdog();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
